// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Assembles big-endian 32-bit words
// from a byte stream and writes them into IMem through its write port. The
// datapath is held in reset until the requested word count has been written.
module imem_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  error_q, error_d;

  // Register all state; reset clears everything including the write-port
  // address/data so they are never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: load decision in IDLE/DONE, byte assembly in RECV,
  // word index advance in WRITE. Write address/data are captured on the
  // fourth byte so they are stable during WRITE and hold afterwards.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    idx_d      = idx_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    error_d    = error_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (load_start) begin
          if (load_count == '0) begin
            state_d = S_DONE;
          end else if (load_count > DEPTH_L) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d      = '0;
            byte_cnt_d = '0;
            count_d    = load_count;
            error_d    = 1'b0;
            state_d    = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (in_valid) begin
          word_d = {word_q[DATA_WIDTH-9:0], in_data};
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            addr_d     = {idx_q[ADDR_WIDTH-3:0], 2'b00};
            wdata_d    = {word_q[DATA_WIDTH-9:0], in_data};
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_d == count_q) state_d = S_DONE;
        else                  state_d = S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the state register only.
  always_comb begin
    in_ready = (state_q == S_RECV);
    imem_we  = (state_q == S_WRITE);
    done     = (state_q == S_DONE);
    cpu_hold = (state_q != S_DONE);
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed vector table, hand-written multi-cycle
// sequences, and randomized loads checked against a word-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [15:0] load_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int ncmp = 0;
  int nfail = 0;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_count(load_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          ls;
    logic [15:0] cnt;
    bit          iv;
    logic [7:0]  d;
    bit          rdy;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wd;
    bit          dn;
    bit          hold;
    bit          err;
    bit          ce;
  } vec_t;

  function automatic vec_t mk(bit ls, logic [15:0] cnt, bit iv, logic [7:0] d,
                              bit rdy, bit we, logic [15:0] addr, logic [31:0] wd,
                              bit dn, bit hold, bit err, bit ce);
    vec_t v;
    v.ls = ls; v.cnt = cnt; v.iv = iv; v.d = d;
    v.rdy = rdy; v.we = we; v.addr = addr; v.wd = wd;
    v.dn = dn; v.hold = hold; v.err = err; v.ce = ce;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // At each falling edge: compare the current outputs, then drive this row's inputs.
  task automatic apply_row(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    chk({tag, ".imem_we"},  32'(imem_we),  32'(v.we));
    chk({tag, ".done"},     32'(done),     32'(v.dn));
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(v.hold));
    if (v.ce) chk({tag, ".error"}, 32'(error), 32'(v.err));
    if (v.we) begin
      chk({tag, ".imem_addr"},  32'(imem_addr), 32'(v.addr));
      chk({tag, ".imem_wdata"}, imem_wdata,     v.wd);
    end
    load_start = v.ls;
    load_count = v.cnt;
    in_valid   = v.iv;
    in_data    = v.d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),  32'd0);
    chk({tag, ".imem_we"},    32'(imem_we),   32'd0);
    chk({tag, ".imem_addr"},  32'(imem_addr), 32'd0);
    chk({tag, ".imem_wdata"}, imem_wdata,     32'd0);
    chk({tag, ".cpu_hold"},   32'(cpu_hold),  32'd1);
    chk({tag, ".done"},       32'(done),      32'd0);
    chk({tag, ".error"},      32'(error),     32'd0);
  endtask

  // Randomized load of n words. The model tracks bytes taken and words
  // written; word k must be bytes 4k..4k+3 (MSB first) at address 4k, written
  // the cycle after its 4th byte is taken; done follows the n-th write.
  task automatic run_rand(input int n, input int vprob);
    logic [7:0]  b[];
    int          taken, written, cyc;
    bit          pend, fin;
    logic [15:0] ea;
    logic [31:0] ed;
    b = new[4 * n];
    foreach (b[i]) b[i] = 8'($urandom);
    @(negedge clk);
    load_start = 1'b1;
    load_count = 16'(n);
    in_valid   = 1'b0;
    in_data    = 8'h00;
    taken = 0; written = 0; cyc = 0; pend = 0; fin = 0; ea = '0; ed = '0;
    forever begin
      @(negedge clk);
      chk("rnd.in_ready", 32'(in_ready), 32'(!fin && !pend));
      chk("rnd.imem_we",  32'(imem_we),  32'(pend));
      chk("rnd.done",     32'(done),     32'(fin));
      chk("rnd.cpu_hold", 32'(cpu_hold), 32'(!fin));
      chk("rnd.error",    32'(error),    32'd0);
      if (pend) begin
        chk("rnd.imem_addr",  32'(imem_addr), 32'(ea));
        chk("rnd.imem_wdata", imem_wdata,     ed);
      end
      if (fin) begin
        load_start = 1'b0;
        in_valid   = 1'b0;
        break;
      end
      cyc++;
      if (cyc > 40 * n + 100) begin
        chk("rnd.done_timeout", 32'(done), 32'd1);
        load_start = 1'b0;
        in_valid   = 1'b0;
        break;
      end
      in_valid   = ($urandom_range(99) < vprob);
      in_data    = (taken < 4 * n) ? b[taken] : 8'($urandom);
      load_start = ($urandom_range(7) == 0);
      load_count = 16'($urandom);
      if (pend) begin
        pend = 0;
        written++;
        if (written == n) fin = 1;
      end else if (in_valid) begin
        taken++;
        if (taken % 4 == 0) begin
          pend = 1;
          ea   = 16'((taken / 4 - 1) * 4);
          ed   = {b[taken-4], b[taken-3], b[taken-2], b[taken-1]};
        end
      end
    end
  endtask

  task automatic run_oversize();
    @(negedge clk);
    load_start = 1'b1;
    load_count = 16'($urandom_range(257, 65535));
    in_valid   = 1'b1;
    @(negedge clk);
    chk("ovr.error",    32'(error),    32'd1);
    chk("ovr.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("ovr.done",     32'(done),     32'd0);
    chk("ovr.in_ready", 32'(in_ready), 32'd0);
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  vec_t tbl[22];

  initial begin
    // Basic load, bounds, and reload from DONE
    tbl[0]  = mk(1, 2,   0, 8'h00, 0, 0, 0, 0,            0, 1, 0, 1);
    tbl[1]  = mk(0, 0,   1, 8'h20, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[2]  = mk(0, 0,   1, 8'h08, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[3]  = mk(0, 0,   1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[4]  = mk(0, 0,   1, 8'h05, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[5]  = mk(0, 0,   0, 8'h00, 0, 1, 0, 32'h20080005, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0,   1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[7]  = mk(0, 0,   1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[8]  = mk(0, 0,   1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[9]  = mk(0, 0,   1, 8'h08, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[10] = mk(0, 0,   0, 8'h00, 0, 1, 4, 32'h00000008, 0, 1, 0, 1);
    tbl[11] = mk(0, 0,   0, 8'h00, 0, 0, 0, 0,            1, 0, 0, 1);
    tbl[12] = mk(1, 0,   0, 8'h00, 0, 0, 0, 0,            1, 0, 0, 1);
    tbl[13] = mk(1, 257, 0, 8'h00, 0, 0, 0, 0,            1, 0, 0, 1);
    tbl[14] = mk(1, 0,   1, 8'hFF, 0, 0, 0, 0,            0, 1, 1, 1);
    tbl[15] = mk(1, 1,   0, 8'h00, 0, 0, 0, 0,            1, 0, 0, 0);
    tbl[16] = mk(0, 0,   1, 8'hDE, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[17] = mk(0, 0,   1, 8'hAD, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[18] = mk(0, 0,   1, 8'hBE, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[19] = mk(0, 0,   1, 8'hEF, 1, 0, 0, 0,            0, 1, 0, 1);
    tbl[20] = mk(0, 0,   0, 8'h00, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 1);
    tbl[21] = mk(0, 0,   0, 8'h00, 0, 0, 0, 0,            1, 0, 0, 1);

    // Reset held with random inputs
    reset = 1'b0;
    load_start = 1'b0; load_count = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load_start = 1'($urandom); load_count = 16'($urandom);
      in_valid   = 1'($urandom); in_data    = 8'($urandom);
      #1;
      chk_reset_vals("rst");
    end
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 22; i++) apply_row(tbl[i], $sformatf("tbl%0d", i));

    // Stalled stream: 3 idle cycles after byte 2, ready held high
    apply_row(mk(1, 2, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "stl0");
    apply_row(mk(0, 0, 1, 8'h20, 1, 0, 0, 0, 0, 1, 0, 1), "stl1");
    apply_row(mk(0, 0, 1, 8'h08, 1, 0, 0, 0, 0, 1, 0, 1), "stl2");
    apply_row(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl3");
    apply_row(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl4");
    apply_row(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl5");
    apply_row(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl6");
    apply_row(mk(0, 0, 1, 8'h05, 1, 0, 0, 0, 0, 1, 0, 1), "stl7");
    apply_row(mk(0, 0, 0, 8'h00, 0, 1, 0, 32'h20080005, 0, 1, 0, 1), "stl8");
    apply_row(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl9");
    apply_row(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl10");
    apply_row(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "stl11");
    apply_row(mk(0, 0, 1, 8'h08, 1, 0, 0, 0, 0, 1, 0, 1), "stl12");
    apply_row(mk(0, 0, 0, 8'h00, 0, 1, 4, 32'h00000008, 0, 1, 0, 1), "stl13");
    apply_row(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "stl14");

    // load_start ignored during RECV and WRITE
    apply_row(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "ign0");
    apply_row(mk(1, 3, 1, 8'h01, 1, 0, 0, 0, 0, 1, 0, 1), "ign1");
    apply_row(mk(0, 0, 1, 8'h02, 1, 0, 0, 0, 0, 1, 0, 1), "ign2");
    apply_row(mk(0, 0, 1, 8'h03, 1, 0, 0, 0, 0, 1, 0, 1), "ign3");
    apply_row(mk(1, 0, 1, 8'h04, 1, 0, 0, 0, 0, 1, 0, 1), "ign4");
    apply_row(mk(1, 5, 1, 8'h99, 0, 1, 0, 32'h01020304, 0, 1, 0, 1), "ign5");
    apply_row(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "ign6");

    // Reset mid-load after byte 2 of word 1, then a clean 1-word load
    apply_row(mk(1, 2, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "rml0");
    apply_row(mk(0, 0, 1, 8'hAA, 1, 0, 0, 0, 0, 1, 0, 1), "rml1");
    apply_row(mk(0, 0, 1, 8'hBB, 1, 0, 0, 0, 0, 1, 0, 1), "rml2");
    apply_row(mk(0, 0, 1, 8'hCC, 1, 0, 0, 0, 0, 1, 0, 1), "rml3");
    apply_row(mk(0, 0, 1, 8'hDD, 1, 0, 0, 0, 0, 1, 0, 1), "rml4");
    apply_row(mk(0, 0, 0, 8'h00, 0, 1, 0, 32'hAABBCCDD, 0, 1, 0, 1), "rml5");
    apply_row(mk(0, 0, 1, 8'h11, 1, 0, 0, 0, 0, 1, 0, 1), "rml6");
    apply_row(mk(0, 0, 1, 8'h22, 1, 0, 0, 0, 0, 1, 0, 1), "rml7");
    apply_row(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1), "rml8");
    #2 reset = 1'b0;
    #1 chk_reset_vals("rml.rst");
    @(negedge clk);
    reset = 1'b1;
    apply_row(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 1), "rml9");
    apply_row(mk(0, 0, 1, 8'h55, 1, 0, 0, 0, 0, 1, 0, 1), "rml10");
    apply_row(mk(0, 0, 1, 8'h66, 1, 0, 0, 0, 0, 1, 0, 1), "rml11");
    apply_row(mk(0, 0, 1, 8'h77, 1, 0, 0, 0, 0, 1, 0, 1), "rml12");
    apply_row(mk(0, 0, 1, 8'h88, 1, 0, 0, 0, 0, 1, 0, 1), "rml13");
    apply_row(mk(0, 0, 0, 8'h00, 0, 1, 0, 32'h55667788, 0, 1, 0, 1), "rml14");
    apply_row(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 1), "rml15");

    // Randomized loads with stalls, stray load_start pulses and oversize requests
    for (int it = 0; it < 8; it++) begin
      run_rand($urandom_range(1, 8), $urandom_range(30, 100));
      if (it % 3 == 1) run_oversize();
    end
    // Full-depth load reaches the last word address 0x03FC
    run_rand(256, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader upstream of the multicycle datapath's instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes the words into IMem through its write port. Holds the datapath in reset until the programmed word count has been written.

## Interface
- DATA_WIDTH, 32, instruction word width (fixed at 32; byte assembly assumes 4 bytes/word)
- ADDR_WIDTH, 16, IMem byte-address width (matches PC width)
- DEPTH_WORDS, 256, IMem capacity in words; upper bound for load_count

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- load_start  input  1  single-cycle pulse; begins a load of load_count words
- load_count  input  ADDR_WIDTH  number of words to load; sampled only on accepted load_start
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  program byte, most significant byte of each word first
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  IMem write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  IMem byte address = word_index*4
- imem_wdata  output  DATA_WIDTH  assembled instruction word
- cpu_hold  output  1  1 = datapath held in reset; 0 = datapath released to run
- done  output  1  load complete; high while in DONE
- error  output  1  sticky: last load_start was rejected (load_count > DEPTH_WORDS)

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: in_ready=0, cpu_hold=1. On load_start, with load_count==0: go to DONE. With 1..DEPTH_WORDS: clear word_index and byte_cnt, clear error, go to RECV. With >DEPTH_WORDS: set error, stay IDLE.
- RECV: in_ready=1. A byte is accepted when in_valid&in_ready. It shifts into the assembly register: word = {word[23:0], in_data}. byte_cnt increments 0..3. The 4th accepted byte moves the FSM to WRITE; byte_cnt wraps to 0.
- WRITE: in_ready=0. imem_we=1 with imem_addr={word_index,2'b00} truncated to ADDR_WIDTH and imem_wdata=assembled word. word_index increments. If the new word_index==load_count, go to DONE; otherwise return to RECV.
- DONE: done=1, cpu_hold=0, in_ready=0. Accepted load_start re-runs the IDLE decision: a valid count re-enters RECV with cpu_hold=1 the next cycle. An oversize count sets error, drops done, goes to IDLE with cpu_hold=1.
- load_start is ignored in RECV and WRITE. in_valid is ignored outside RECV.
- imem_addr/imem_wdata hold their last values when imem_we=0. They are don't-care for IMem but must not be X after reset.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, state=IDLE.
- All outputs are registered or decoded from the state register only. No combinational path from in_valid to in_ready.
- Per word: 4 accept cycles (minimum) + 1 WRITE cycle. Minimum load time for N words is 1 + 5N cycles from load_start to done.
- Gaps in in_valid stall RECV indefinitely with no timeout. Partial bytes are retained.
- cpu_hold deasserts in the same cycle done asserts, one cycle after the final WRITE.
- Reset asserted mid-load aborts immediately to reset values. Words already written stay in IMem. The loader does not clear IMem.
- Last word with DEPTH_WORDS=256: word_index 255 gives imem_addr=0x03FC. No wrap occurs because the count is bounded.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs at reset values. Release -> IDLE, cpu_hold=1.
- Basic load: load_count=2, bytes 20,08,00,05,00,00,00,08 back-to-back -> imem_we at cycles 5 and 10. Writes are (addr 0x0000, 0x20080005) and (0x0004, 0x00000008). done=1 and cpu_hold=0 at cycle 11.
- Stalled stream: same load with in_valid deasserted for 3 cycles after byte 2 -> identical write data and addresses. done is 3 cycles later. in_ready stays 1 during the stall.
- Bounds: load_count=0 -> done=1 one cycle after load_start, no imem_we. load_count=257 -> error=1, stays IDLE, cpu_hold=1, in_ready=0.
- Reload/ignore: load_start pulsed during RECV -> ignored, and the load completes with the original count. load_start=1 with count=1 in DONE -> cpu_hold returns to 1 next cycle, and the word is rewritten at 0x0000.
- Reset mid-load: assert reset after byte 2 of word 1 -> outputs reset immediately. A new load of 1 word writes the correct word with no stale bytes.
